// File: rtl/cpc_mem_arbiter.sv
// cpc_mem_arbiter: shares one SDRAM request port between video, CPU and boot loader
//  Ports: clk_sys/reset_n (sync, active low); boot_mode selects boot-only service.
//  vid_*  : video read port (req level, ack pulse, 16-bit word)
//  cpu_*  : CPU port, byte access with lane from cpu_addr[0], bank, read/write
//  boot_* : boot loader write port
//  mem_*  : SDRAM side, mem_req is a one-cycle issue strobe, mem_rdy the completion
//  timeout_err : sticky flag set when a transaction got no mem_rdy in time
module cpc_mem_arbiter #(
  parameter int AW = 23,
  parameter int CPU_STARVE = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          boot_mode,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [15:0]   vid_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [1:0]    cpu_bank,
  input  logic [7:0]    cpu_din,
  output logic          cpu_ack,
  output logic [7:0]    cpu_dout,
  input  logic          boot_req,
  input  logic [AW-1:0] boot_addr,
  input  logic [1:0]    boot_bank,
  input  logic [7:0]    boot_din,
  output logic          boot_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [1:0]    mem_bank,
  output logic [7:0]    mem_din,
  input  logic          mem_rdy,
  input  logic [15:0]   mem_dout,
  output logic          timeout_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t      state_q;
  logic [2:0]  gnt_q;
  logic [2:0]  win;
  logic [3:0]  starve_q;
  logic [7:0]  wait_q;
  logic        hold_q;
  logic [15:0] rd_word;
  // win/gnt encoding: bit0 video, bit1 cpu, bit2 boot.
  // The IDLE cycle after a completion grants nobody, so the acked requester can
  // drop its request while the others keep their fixed-priority order.
  always_comb begin
    win = hold_q ? 3'b000 :
          boot_mode ? {boot_req, 2'b00} :
          (cpu_req && starve_q == 4'(CPU_STARVE)) ? 3'b010 :
          vid_req ? 3'b001 :
          cpu_req ? 3'b010 : 3'b000;
    rd_word = mem_rdy ? mem_dout : 16'hFFFF;
  end
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      starve_q    <= '0;
      wait_q      <= '0;
      hold_q      <= 1'b0;
      vid_ack     <= 1'b0;
      cpu_ack     <= 1'b0;
      boot_ack    <= 1'b0;
      vid_data    <= '0;
      cpu_dout    <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_bank    <= '0;
      mem_din     <= '0;
      timeout_err <= 1'b0;
    end else begin
      vid_ack  <= 1'b0;
      cpu_ack  <= 1'b0;
      boot_ack <= 1'b0;
      mem_req  <= 1'b0;
      hold_q   <= 1'b0;
      if (!cpu_req) starve_q <= '0;
      case (state_q)
        IDLE: if (|win) begin
          state_q  <= ISSUE;
          gnt_q    <= win;
          mem_req  <= 1'b1;
          wait_q   <= '0;
          mem_we   <= win[2] | (win[1] & cpu_we);
          mem_addr <= win[0] ? vid_addr : win[1] ? cpu_addr : boot_addr;
          mem_bank <= win[1] ? cpu_bank : win[2] ? boot_bank : 2'b00;
          mem_din  <= win[1] ? cpu_din : win[2] ? boot_din : 8'h00;
          if (win[1]) starve_q <= '0;
          else if (win[0] && cpu_req && starve_q != 4'(CPU_STARVE)) starve_q <= starve_q + 4'd1;
        end
        ISSUE: state_q <= WAIT;
        WAIT: if (mem_rdy || wait_q == 8'(TIMEOUT - 1)) begin
          state_q  <= DONE;
          vid_ack  <= gnt_q[0];
          cpu_ack  <= gnt_q[1];
          boot_ack <= gnt_q[2];
          if (!mem_rdy) timeout_err <= 1'b1;
          if (gnt_q[0]) vid_data <= rd_word;
          if (gnt_q[1] && !mem_we) cpu_dout <= mem_addr[0] ? rd_word[15:8] : rd_word[7:0];
        end else wait_q <= wait_q + 8'd1;
        DONE: begin
          state_q <= IDLE;
          hold_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpc_mem_arbiter.sv
// tb_cpc_mem_arbiter: directed self-checking bench for cpc_mem_arbiter
module tb_cpc_mem_arbiter;
  localparam int AW = 23;
  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          boot_mode = 1'b0;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_ack;
  logic [15:0]   vid_data;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [1:0]    cpu_bank = '0;
  logic [7:0]    cpu_din = '0;
  logic          cpu_ack;
  logic [7:0]    cpu_dout;
  logic          boot_req = 1'b0;
  logic [AW-1:0] boot_addr = '0;
  logic [1:0]    boot_bank = '0;
  logic [7:0]    boot_din = '0;
  logic          boot_ack;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_bank;
  logic [7:0]    mem_din;
  logic          mem_rdy = 1'b0;
  logic [15:0]   mem_dout = '0;
  logic          timeout_err;

  always #5 clk_sys = ~clk_sys;

  cpc_mem_arbiter #(.AW(AW), .CPU_STARVE(4), .TIMEOUT(15)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .boot_mode(boot_mode),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_bank(cpu_bank),
    .cpu_din(cpu_din), .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .boot_req(boot_req), .boot_addr(boot_addr), .boot_bank(boot_bank),
    .boot_din(boot_din), .boot_ack(boot_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_bank(mem_bank),
    .mem_din(mem_din), .mem_rdy(mem_rdy), .mem_dout(mem_dout), .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SDRAM responder: mem_rdy rdy_dly WAIT cycles after the issue strobe (0 = never)
  int          rdy_dly = 1;
  int          pend = 0;
  logic [15:0] rdy_word = '0;
  logic        spur = 1'b0;
  always @(negedge clk_sys) begin
    mem_rdy = spur;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        mem_rdy = 1'b1;
        mem_dout = rdy_word;
      end
    end
    if (mem_req && rdy_dly > 0) pend = rdy_dly;
  end

  // monitor: counts issue strobes and acks, captures the issued command
  int            n_req = 0, n_vack = 0, n_cack = 0, n_back = 0;
  logic          cap_we = 1'b0;
  logic [7:0]    cap_din = '0;
  logic [AW-1:0] cap_addr = '0;
  logic [1:0]    cap_bank = '0;
  always @(negedge clk_sys) begin
    if (mem_req) begin
      n_req++;
      cap_we = mem_we;
      cap_din = mem_din;
      cap_addr = mem_addr;
      cap_bank = mem_bank;
    end
    n_vack += int'(vid_ack);
    n_cack += int'(cpu_ack);
    n_back += int'(boot_ack);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // cyc-1 = cycles from the IDLE cycle the request was driven in to the ack cycle
  task automatic wait_any_ack(output int cyc, output logic [2:0] acks);
    cyc = 0;
    acks = '0;
    while (acks == 3'b000 && cyc < 100) begin
      @(negedge clk_sys);
      cyc++;
      acks = {boot_ack, cpu_ack, vid_ack};
    end
  endtask

  int         cyc;
  logic [2:0] acks;
  logic [29:0] got_o, exp_o;
  int s_req, s_v, s_c, s_b;

  initial begin
    tick(2);
    check("rst_ctl", {vid_ack, cpu_ack, boot_ack, mem_req, mem_we, timeout_err}, 0);
    check("rst_mem", {mem_addr, mem_bank, mem_din}, 0);
    check("rst_data", {vid_data, cpu_dout}, 0);
    reset_n = 1'b1;
    tick(2);
    // minimum latency video read
    rdy_dly = 1; rdy_word = 16'h1234; vid_addr = 23'h000456; vid_req = 1'b1;
    wait_any_ack(cyc, acks);
    check("vid_lat", cyc - 1, 3);
    check("vid_ack", acks, 3'b001);
    check("vid_data", vid_data, 16'h1234);
    check("vid_cmd", {cap_we, cap_bank, cap_addr}, {1'b0, 2'b00, 23'h000456});
    tick(1); vid_req = 1'b0;
    tick(2);
    // starvation: V,V,V,V,C,V,V,V,V,C
    cpu_we = 1'b0; cpu_addr = 23'h000010; vid_req = 1'b1; cpu_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_any_ack(cyc, acks);
      got_o[i*3 +: 3] = acks;
      exp_o[i*3 +: 3] = (i == 4 || i == 9) ? 3'b010 : 3'b001;
    end
    check("grant_order", got_o, exp_o);
    tick(1); vid_req = 1'b0; cpu_req = 1'b0;
    tick(2);
    // cpu read, high lane, rdy on 2nd WAIT cycle
    rdy_dly = 2; rdy_word = 16'hA55A; cpu_addr = 23'h000101; cpu_we = 1'b0; cpu_req = 1'b1;
    wait_any_ack(cyc, acks);
    check("cpu_lat", cyc - 1, 4);
    check("cpu_ack", acks, 3'b010);
    check("cpu_dout_hi", cpu_dout, 8'hA5);
    check("cpu_rd_we", cap_we, 1'b0);
    tick(1); cpu_req = 1'b0;
    tick(2);
    // cpu read, low lane
    rdy_dly = 1; cpu_addr = 23'h000100; cpu_req = 1'b1;
    wait_any_ack(cyc, acks);
    check("cpu_lo_lat", cyc - 1, 3);
    check("cpu_dout_lo", cpu_dout, 8'h5A);
    tick(1); cpu_req = 1'b0;
    tick(2);
    // cpu write leaves cpu_dout alone
    rdy_word = 16'h0F0F; cpu_we = 1'b1; cpu_din = 8'h77; cpu_bank = 2'd2; cpu_addr = 23'h000200; cpu_req = 1'b1;
    wait_any_ack(cyc, acks);
    check("cpu_wr_ack", acks, 3'b010);
    check("cpu_wr_cmd", {cap_we, cap_bank, cap_din, cap_addr}, {1'b1, 2'd2, 8'h77, 23'h000200});
    check("cpu_wr_dout", cpu_dout, 8'h5A);
    tick(1); cpu_req = 1'b0; cpu_we = 1'b0;
    tick(2);
    // boot mode: only boot served
    boot_mode = 1'b1; vid_req = 1'b1; cpu_req = 1'b1;
    boot_addr = 23'h1FF000; boot_din = 8'h3C; boot_bank = 2'd1; boot_req = 1'b1;
    wait_any_ack(cyc, acks);
    check("boot_ack", acks, 3'b100);
    check("boot_lat", cyc - 1, 3);
    check("boot_cmd", {cap_we, cap_bank, cap_din, cap_addr}, {1'b1, 2'd1, 8'h3C, 23'h1FF000});
    tick(1); boot_req = 1'b0;
    s_req = n_req; s_v = n_vack; s_c = n_cack;
    tick(10);
    check("boot_excl", {n_req - s_req, n_vack - s_v, n_cack - s_c}, 0);
    vid_req = 1'b0; cpu_req = 1'b0; boot_mode = 1'b0;
    tick(2);
    // timeout
    check("tmo_pre", timeout_err, 1'b0);
    rdy_dly = 0; vid_addr = 23'h000777; vid_req = 1'b1;
    wait_any_ack(cyc, acks);
    check("tmo_lat", cyc - 1, 17);
    check("tmo_ack", acks, 3'b001);
    check("tmo_data", vid_data, 16'hFFFF);
    tick(1); vid_req = 1'b0;
    tick(5);
    check("tmo_sticky", timeout_err, 1'b1);
    // reset while in WAIT
    cpu_addr = 23'h000001; cpu_req = 1'b1;
    tick(3);
    reset_n = 1'b0; cpu_req = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("wrst_ctl", {vid_ack, cpu_ack, boot_ack, mem_req, mem_we, timeout_err}, 0);
    check("wrst_data", {vid_data, cpu_dout, mem_addr, mem_bank, mem_din}, 0);
    s_req = n_req; s_v = n_vack; s_c = n_cack; s_b = n_back;
    tick(20);
    check("wrst_quiet", {n_req - s_req, n_vack - s_v, n_cack - s_c, n_back - s_b}, 0);
    rdy_dly = 1; rdy_word = 16'hBEEF; cpu_req = 1'b1;
    wait_any_ack(cyc, acks);
    check("wrst_cpu_lat", cyc - 1, 3);
    check("wrst_cpu_dout", {acks, cpu_dout}, {3'b010, 8'hBE});
    tick(1); cpu_req = 1'b0;
    tick(2);
    // mem_rdy while idle is ignored
    s_req = n_req; s_v = n_vack; s_c = n_cack; s_b = n_back;
    spur = 1'b1;
    tick(1);
    spur = 1'b0;
    tick(3);
    check("spur_quiet", {n_req - s_req, n_vack - s_v, n_cack - s_c, n_back - s_b}, 0);
    check("spur_ctl", {mem_req, vid_ack, cpu_ack, boot_ack}, 0);
    rdy_word = 16'h4321; vid_req = 1'b1;
    wait_any_ack(cyc, acks);
    check("spur_after_lat", cyc - 1, 3);
    check("spur_after_data", vid_data, 16'h4321);
    tick(1); vid_req = 1'b0;
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
